// File: rtl/half_adder_pkg.sv
// Shared defaults, the per-lane result type and the single-bit half-add helper.
package half_adder_pkg;

  localparam int unsigned DefWidth = 1;
  localparam int unsigned DefCntW  = 8;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_result_t;

  // One-bit half add: sum is the XOR, carry is the AND.
  function automatic ha_result_t ha_eval(input logic a, input logic b);
    ha_result_t r;
    r.sum   = a ^ b;
    r.carry = a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder.
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  ha_result_t res;

  // Evaluate the lane with the shared helper so every lane uses identical logic.
  always_comb begin
    res = ha_eval(a, b);
  end

  assign sum   = res.sum;
  assign carry = res.carry;

endmodule

// File: rtl/half_adder.sv
// Bit-parallel half adder: combinational outputs, a one-cycle registered copy
// with a valid flag, and a saturating count of accepted cycles carrying out.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  // Lanes are fully independent; no carry ripples between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             valid_d;
  logic [CNT_W-1:0] count_d;
  logic             count_sat;

  assign count_sat = (carry_count == {CNT_W{1'b1}});

  // Next state: capture on in_valid, otherwise hold data and drop valid.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    count_d = carry_count;
    if (in_valid) begin
      sum_d   = sum;
      carry_d = carry;
      valid_d = 1'b1;
      // Count once per cycle no matter how many lanes carry; never wrap.
      if (|carry && !count_sat) begin
        count_d = carry_count + 1'b1;
      end
    end
  end

  // Output register, valid flop and counter; async reset discards in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid   <= 1'b0;
      carry_count <= '0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid   <= valid_d;
      carry_count <= count_d;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder (WIDTH=4, CNT_W=2).
module tb_half_adder;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic [W-1:0]  sum;
  logic [W-1:0]  carry;
  logic [W-1:0]  sum_q;
  logic [W-1:0]  carry_q;
  logic          out_valid;
  logic [CW-1:0] carry_count;

  typedef struct {
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [CW-1:0] n;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  half_adder #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .sum         (sum),
    .carry       (carry),
    .sum_q       (sum_q),
    .carry_q     (carry_q),
    .out_valid   (out_valid),
    .carry_count (carry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one accepted vector just after a rising edge and queue its expected result.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] es, input logic [W-1:0] ec,
                       input logic [CW-1:0] en);
    exp_t e;
    @(posedge clk);
    #1;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    e.s = es;
    e.c = ec;
    e.n = en;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_sum_q", 8'(sum_q), 8'h0);
    check("rst_carry_q", 8'(carry_q), 8'h0);
    check("rst_out_valid", 8'(out_valid), 8'h0);
    check("rst_count", 8'(carry_count), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: whenever the DUT presents a registered result, compare with the queue head.
  always @(negedge clk) begin
    if (!done && rst_n && out_valid) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: out_valid with empty queue at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (sum_q !== e.s || carry_q !== e.c || carry_count !== e.n) begin
          errors++;
          $display("FAIL sb_result: got s=%b c=%b n=%0d expected s=%b c=%b n=%0d at %0t",
                   sum_q, carry_q, carry_count, e.s, e.c, e.n, $time);
        end
      end
    end
  end

  logic [1:0] va_tab [4];
  logic [1:0] exp_tab [4];

  initial begin
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    va_tab   = '{2'b00, 2'b11, 2'b10, 2'b01};  // {a,b}
    exp_tab  = '{2'b00, 2'b01, 2'b10, 2'b10};  // {sum,carry}

    // Reset state, held across an edge even with in_valid high.
    #1;
    check("init_out_valid", 8'(out_valid), 8'h0);
    in_valid = 1'b1;
    a = 4'b0001;
    b = 4'b0001;
    @(posedge clk);
    #1;
    check("held_rst_carry_q", 8'(carry_q), 8'h0);
    check("held_rst_count", 8'(carry_count), 8'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive combinational on lane 0, 40 ns per vector, sequence repeated.
    $monitor("t=%0t a=%b b=%b sum=%b carry=%b", $time, a, b, sum, carry);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        a = {3'b000, va_tab[i][1]};
        b = {3'b000, va_tab[i][0]};
        #1;
        check("comb_sum", 8'(sum), 8'({3'b000, exp_tab[i][1]}));
        check("comb_carry", 8'(carry), 8'({3'b000, exp_tab[i][0]}));
        #39;
      end
    end
    $monitoroff;

    // Registered latency then hold with in_valid low.
    issue(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 4'b0000;
    b = 4'b0000;
    check("lat_out_valid", 8'(out_valid), 8'h1);
    check("lat_carry_q", 8'(carry_q), 8'h1);
    @(posedge clk);
    #1;
    check("hold_out_valid", 8'(out_valid), 8'h0);
    check("hold_sum_q", 8'(sum_q), 8'h0);
    check("hold_carry_q", 8'(carry_q), 8'h1);
    check("hold_count", 8'(carry_count), 8'h1);

    // Async reset between edges discards the in-flight capture.
    issue(4'b0011, 4'b0001, 4'b0010, 4'b0001, 2'd2);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    do_reset();
    a = 4'b0001;
    b = 4'b0000;
    #1;
    check("rst_comb_sum", 8'(sum), 8'h1);
    check("rst_comb_carry", 8'(carry), 8'h0);

    // Multi-lane: one count step even with two carrying lanes... here one lane carries.
    a = 4'b1100;
    b = 4'b1010;
    #1;
    check("ml_sum", 8'(sum), 8'h6);
    check("ml_carry", 8'(carry), 8'h8);
    issue(4'b1100, 4'b1010, 4'b0110, 4'b1000, 2'd1);
    issue(4'b1111, 4'b0101, 4'b1010, 4'b0101, 2'd2);
    idle();
    @(posedge clk);
    #1;
    check("ml_count", 8'(carry_count), 8'h2);

    // Saturation at 3; a=1,b=0 cycles leave the count alone.
    @(negedge clk);
    do_reset();
    issue(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd1);
    issue(4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd1);
    issue(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd2);
    issue(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd3);
    issue(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd3);
    issue(4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd3);
    issue(4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd3);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("sat_count", 8'(carry_count), 8'h3);

    // Every queued expectation must have been consumed by the monitor.
    check("sb_drained", 8'(exp_q.size()), 8'h0);
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
